// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing generator with pixel prescaler and a sync/blank pipeline aligned to image logic.
// Optional 8-bar test pattern on r,g,b when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYN    = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYN    = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 2,
    parameter int CW       = 10
) (
    input  logic          ref_clk,
    input  logic          rst,
    input  logic          en,
    input  logic [23:0]   rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          pat_sel,
`endif
    output logic          vga_clk,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          h_sync,
    output logic          v_sync,
    output logic          sync_b,
    output logic          blank_b,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYN + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYN + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
`ifdef VGA_TEST_PATTERN_EN
    localparam int PW      = 3 + CW;
`else
    localparam int PW      = 3;
`endif

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic          r_vga_clk;
    logic          w_pix_ce;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          w_x_end;
    logic          w_y_end;
    logic          w_hs;
    logic          w_vs;
    logic          w_de;
    logic [PW-1:0] w_dec;
    logic [PW-1:0] w_tap;
    logic [23:0]   w_src;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_syncb;
    logic          r_blankb;
    logic [23:0]   r_rgb;

    assign w_pix_ce  = r_div == DW'(CLK_DIV - 1);
    assign w_div_nxt = w_pix_ce ? '0 : r_div + 1'b1;

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_vga_clk <= w_div_nxt < DW'(CLK_DIV / 2);
        end
    end

    assign w_x_end = r_x == CW'(H_TOTAL - 1);
    assign w_y_end = r_y == CW'(V_TOTAL - 1);

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (!en) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pix_ce) begin
            r_x <= w_x_end ? '0 : r_x + 1'b1;
            if (w_x_end)
                r_y <= w_y_end ? '0 : r_y + 1'b1;
        end
    end

    assign w_hs = (r_x >= CW'(H_ACTIVE + H_FP)) && (r_x < CW'(H_ACTIVE + H_FP + H_SYN));
    assign w_vs = (r_y >= CW'(V_ACTIVE + V_FP)) && (r_y < CW'(V_ACTIVE + V_FP + V_SYN));
    assign w_de = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));
`ifdef VGA_TEST_PATTERN_EN
    assign w_dec = {r_x, w_hs, w_vs, w_de};
`else
    assign w_dec = {w_hs, w_vs, w_de};
`endif

    // All-zero stage contents mean hs/vs/de inactive, so a flush is just a clear.
    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign w_tap = w_dec;
        end else begin : g_dly
            logic [PW-1:0] r_sr [PIPE_DLY];
            always_ff @(posedge ref_clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) r_sr[i] <= '0;
                end else if (!en) begin
                    for (int i = 0; i < PIPE_DLY; i++) r_sr[i] <= '0;
                end else if (w_pix_ce) begin
                    r_sr[0] <= w_dec;
                    for (int i = 1; i < PIPE_DLY; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_tap = r_sr[PIPE_DLY-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    logic [CW-1:0] w_tx;
    logic [2:0]    w_bar;
    logic [23:0]   w_pat;
    assign w_tx  = w_tap[PW-1:3];
    assign w_bar = 3'({w_tx, 3'b000} / (CW+3)'(H_ACTIVE));
    // Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black.
    assign w_pat = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
    assign w_src = pat_sel ? w_pat : rgb_in;
`else
    assign w_src = rgb_in;
`endif

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            r_hsync  <= ~H_POL;
            r_vsync  <= ~V_POL;
            r_syncb  <= 1'b1;
            r_blankb <= 1'b0;
            r_rgb    <= '0;
        end else if (!en) begin
            r_hsync  <= ~H_POL;
            r_vsync  <= ~V_POL;
            r_syncb  <= 1'b1;
            r_blankb <= 1'b0;
            r_rgb    <= '0;
        end else if (w_pix_ce) begin
            r_hsync  <= w_tap[2] ~^ H_POL;
            r_vsync  <= w_tap[1] ~^ V_POL;
            r_syncb  <= ~(w_tap[2] | w_tap[1]);
            r_blankb <= w_tap[0];
            r_rgb    <= w_tap[0] ? w_src : '0;
        end
    end

    assign vga_clk     = r_vga_clk;
    assign pix_ce      = w_pix_ce;
    assign x           = r_x;
    assign y           = r_y;
    assign de          = w_de;
    assign line_start  = w_pix_ce & en & (r_x == '0);
    assign frame_start = line_start & (r_y == '0);
    assign h_sync      = r_hsync;
    assign v_sync      = r_vsync;
    assign sync_b      = r_syncb;
    assign blank_b     = r_blankb;
    assign {r, g, b}   = r_rgb;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-stimulus bench for two vga_timing_gen configurations against a pixel-index model.
module tb_vga_timing_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = 5;

    logic ref_clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic [23:0] rgb_in = '0;
`ifdef VGA_TEST_PATTERN_EN
    logic pat_sel = 1'b0;
`endif

    logic          d_vclk [2];
    logic          d_ce [2];
    logic [CW-1:0] d_x [2];
    logic [CW-1:0] d_y [2];
    logic          d_de [2];
    logic          d_ls [2];
    logic          d_fs [2];
    logic          d_hs [2];
    logic          d_vs [2];
    logic          d_sb [2];
    logic          d_bb [2];
    logic [7:0]    d_r [2];
    logic [7:0]    d_g [2];
    logic [7:0]    d_b [2];

    int total = 0;
    int bad = 0;

    initial forever #5 ref_clk = ~ref_clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYN(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYN(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(2), .PIPE_DLY(2), .CW(CW)
    ) dut_a (
        .ref_clk(ref_clk), .rst(rst), .en(en), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .pat_sel(pat_sel),
`endif
        .vga_clk(d_vclk[0]), .pix_ce(d_ce[0]), .x(d_x[0]), .y(d_y[0]), .de(d_de[0]),
        .line_start(d_ls[0]), .frame_start(d_fs[0]), .h_sync(d_hs[0]), .v_sync(d_vs[0]),
        .sync_b(d_sb[0]), .blank_b(d_bb[0]), .r(d_r[0]), .g(d_g[0]), .b(d_b[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYN(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYN(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(4), .PIPE_DLY(0), .CW(CW)
    ) dut_b (
        .ref_clk(ref_clk), .rst(rst), .en(en), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .pat_sel(pat_sel),
`endif
        .vga_clk(d_vclk[1]), .pix_ce(d_ce[1]), .x(d_x[1]), .y(d_y[1]), .de(d_de[1]),
        .line_start(d_ls[1]), .frame_start(d_fs[1]), .h_sync(d_hs[1]), .v_sync(d_vs[1]),
        .sync_b(d_sb[1]), .blank_b(d_bb[1]), .r(d_r[1]), .g(d_g[1]), .b(d_b[1])
    );

    function automatic int cd(int i);
        return i == 0 ? 2 : 4;
    endfunction
    function automatic int pd(int i);
        return i == 0 ? 2 : 0;
    endfunction
    function automatic bit pol(int i);
        return i != 0;
    endfunction
    function automatic int px(int n);
        return (n % (HT * VT)) % HT;
    endfunction
    function automatic int py(int n);
        return (n % (HT * VT)) / HT;
    endfunction
    function automatic bit in_hs(int xx);
        return xx >= HA + HF && xx < HA + HF + HS;
    endfunction
    function automatic bit in_vs(int yy);
        return yy >= VA + VF && yy < VA + VF + VS;
    endfunction
    function automatic bit in_de(int xx, int yy);
        return xx < HA && yy < VA;
    endfunction
    function automatic logic [23:0] bar(int xx);
        case (xx * 8 / HA)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Model: m_edges counts ref_clk edges since reset, m_n counts enabled pixel ticks since restart.
    int          m_edges [2];
    int          m_n [2];
    logic        e_hs [2];
    logic        e_vs [2];
    logic        e_de [2];
    logic [23:0] e_rgb [2];

    always @(posedge ref_clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            int p;
            if (!rst) begin
                m_edges[i] = 0;
                m_n[i] = 0;
                e_hs[i] = 0; e_vs[i] = 0; e_de[i] = 0; e_rgb[i] = '0;
            end else begin
                m_edges[i]++;
                if (!en) begin
                    m_n[i] = 0;
                    e_hs[i] = 0; e_vs[i] = 0; e_de[i] = 0; e_rgb[i] = '0;
                end else if (m_edges[i] % cd(i) == 0) begin
                    p = m_n[i] - pd(i);
                    m_n[i]++;
                    if (p < 0) begin
                        e_hs[i] = 0; e_vs[i] = 0; e_de[i] = 0; e_rgb[i] = '0;
                    end else begin
                        e_hs[i] = in_hs(px(p));
                        e_vs[i] = in_vs(py(p));
                        e_de[i] = in_de(px(p), py(p));
`ifdef VGA_TEST_PATTERN_EN
                        e_rgb[i] = e_de[i] ? (pat_sel ? bar(px(p)) : rgb_in) : 24'h0;
`else
                        e_rgb[i] = e_de[i] ? rgb_in : 24'h0;
`endif
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int fs_cnt = 0;
    bit fs_armed = 0;

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int xx, yy;
            bit ce, ls, vc;
            xx = px(m_n[i]);
            yy = py(m_n[i]);
            ce = ((m_edges[i] + 1) % cd(i)) == 0;
            ls = ce && en && xx == 0;
            vc = m_edges[i] != 0 && (m_edges[i] % cd(i)) < cd(i) / 2;
            chk($sformatf("x%0d", i), 32'(d_x[i]), 32'(xx));
            chk($sformatf("y%0d", i), 32'(d_y[i]), 32'(yy));
            chk($sformatf("de%0d", i), 32'(d_de[i]), 32'(in_de(xx, yy)));
            chk($sformatf("pix_ce%0d", i), 32'(d_ce[i]), 32'(ce));
            chk($sformatf("vga_clk%0d", i), 32'(d_vclk[i]), 32'(vc));
            chk($sformatf("line_start%0d", i), 32'(d_ls[i]), 32'(ls));
            chk($sformatf("frame_start%0d", i), 32'(d_fs[i]), 32'(ls && yy == 0));
            chk($sformatf("h_sync%0d", i), 32'(d_hs[i]), 32'(e_hs[i] ? pol(i) : !pol(i)));
            chk($sformatf("v_sync%0d", i), 32'(d_vs[i]), 32'(e_vs[i] ? pol(i) : !pol(i)));
            chk($sformatf("sync_b%0d", i), 32'(d_sb[i]), 32'(!(e_hs[i] || e_vs[i])));
            chk($sformatf("blank_b%0d", i), 32'(d_bb[i]), 32'(e_de[i]));
            chk($sformatf("rgb%0d", i), 32'({d_r[i], d_g[i], d_b[i]}), 32'(e_rgb[i]));
        end
        if (!rst || !en) begin
            fs_armed = 0;
        end else if (d_ce[0]) begin
            fs_cnt++;
            if (d_fs[0]) begin
                if (fs_armed) chk("fs_period", 32'(fs_cnt), 32'(HT * VT));
                fs_armed = 1;
                fs_cnt = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge ref_clk);
        check_all();
        rgb_in = $urandom;
`ifdef VGA_TEST_PATTERN_EN
        pat_sel = $urandom_range(0, 3) != 0;
`endif
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_xy(input int wx, input int wy);
        int k;
        for (k = 0; k < 2000 && !(32'(d_x[0]) == wx && 32'(d_y[0]) == wy); k++) step();
        chk("wait_xy", 32'(k < 2000), 32'd1);
    endtask

    initial begin
        run(3);
        rst = 1'b1;
        en = 1'b1;
        run(1200);
        wait_xy(0, 3);
        en = 1'b0;
        run(6);
        en = 1'b1;
        run(300);
        for (int k = 0; k < 600; k++) begin
            en = $urandom_range(0, 15) != 0;
            step();
        end
        en = 1'b1;
        run(10);
        wait_xy(5, 3);
        #2 rst = 1'b0;
        #1 check_all();
        step();
        rst = 1'b1;
        run(800);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
